// File: rtl/ipu_pkg.sv
// Shared types and constants for the merge scheduler: FSM state encoding,
// requester port indices, select token width and small port-index helpers.
// No ports; imported by merge_scheduler and rr_pick3.
package ipu_pkg;

  localparam int SEL_W = 2;

  localparam logic [1:0] PORT_IN1  = 2'd0;
  localparam logic [1:0] PORT_IN2  = 2'd1;
  localparam logic [1:0] PORT_CORE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  // Next port in round-robin order, wrapping core back to input1.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == PORT_CORE) ? PORT_IN1 : p + 2'd1;
  endfunction

  // Index of a one-hot 3-bit grant; an empty vector maps to input1.
  function automatic logic [1:0] onehot_to_port(input logic [2:0] oh);
    logic [1:0] p;
    p = PORT_IN1;
    if (oh[2]) p = PORT_CORE;
    else if (oh[1]) p = PORT_IN2;
    return p;
  endfunction

endpackage

// File: rtl/merge_scheduler_rr_pick3.sv
// Combinational 3-way round-robin picker with core override.
// Zero latency; no backpressure (pure function of req/ptr/core_prio).
// Ports: req (3 requests), ptr (search start port), core_prio, win (one-hot).
module rr_pick3
  import ipu_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic       core_prio,
  output logic [2:0] win
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = ptr;
    if (core_prio && req[PORT_CORE]) begin
      win[PORT_CORE] = 1'b1;
    end else begin
      // Walk the three ports starting at ptr; first requester wins.
      for (int i = 0; i < 3; i++) begin
        if (!found && req[idx]) begin
          win[idx] = 1'b1;
          found    = 1'b1;
        end
        idx = next_port(idx);
      end
    end
  end

endmodule

// File: rtl/merge_scheduler.sv
// Grants one of three requesters, offers its select token to the merge and
// waits for the merge to deliver (done) or for the XFER watchdog to expire.
// Latency: grant/token visible 1 cycle after a request is seen in IDLE.
// Backpressure: token held (OFFER) until sel_ready; grant held until done.
// Ports: clk, rst_n, req[2:0], core_prio -> gnt[2:0], sel_valid, sel,
//        sel_ready, done -> busy, timeout_err (sticky), gnt_cnt (3 counters).
module merge_scheduler #(
  parameter int SEL_W   = ipu_pkg::SEL_W,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         req,
  input  logic               core_prio,
  output logic [2:0]         gnt,
  output logic               sel_valid,
  output logic [SEL_W-1:0]   sel,
  input  logic               sel_ready,
  input  logic               done,
  output logic               busy,
  output logic               timeout_err,
  output logic [3*CNT_W-1:0] gnt_cnt
);

  import ipu_pkg::*;

  localparam int WD_W = 16;

  state_t            state;
  logic [1:0]        ptr;
  logic [1:0]        cur;
  logic [WD_W-1:0]   wd;
  logic [CNT_W-1:0]  cnt [3];
  logic [2:0]        win;
  logic [1:0]        win_port;

  rr_pick3 u_pick (
    .req       (req),
    .ptr       (ptr),
    .core_prio (core_prio),
    .win       (win)
  );

  assign win_port = onehot_to_port(win);
  assign gnt_cnt  = {cnt[2], cnt[1], cnt[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= PORT_IN1;
      cur         <= PORT_IN1;
      wd          <= '0;
      gnt         <= '0;
      sel_valid   <= 1'b0;
      sel         <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state     <= ST_OFFER;
            gnt       <= win;
            cur       <= win_port;
            sel       <= SEL_W'(win_port);
            sel_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        // Offer is never withdrawn, even if the requester drops req.
        ST_OFFER: begin
          if (sel_ready) begin
            state     <= ST_XFER;
            sel_valid <= 1'b0;
            wd        <= '0;
          end
        end
        ST_XFER: begin
          if (done) begin
            for (int i = 0; i < 3; i++) begin
              if (gnt[i]) cnt[i] <= cnt[i] + 1'b1;
            end
            ptr   <= next_port(cur);
            state <= ST_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            // Abort: rotate fairness as if completed, but count nothing.
            timeout_err <= 1'b1;
            ptr         <= next_port(cur);
            state       <= ST_IDLE;
            gnt         <= '0;
            busy        <= 1'b0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
